// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALUOp classes, control-field layout
// and the main control decoder used by the ID stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // wb_ctl = {RegWrite, MemtoReg}, m_ctl = {Branch, MemRead, MemWrite}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic       regdst;
    logic [1:0] aluop;
    logic       alusrc;
  } ctl_t;

  // Unrecognised opcodes fall through to an all-zero bubble.
  function automatic ctl_t decode_ctl(input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.regdst          = 1'b1;
        c.aluop           = ALUOP_FUNCT;
        c.wb[WB_REGWRITE] = 1'b1;
      end
      OP_LW: begin
        c.alusrc          = 1'b1;
        c.aluop           = ALUOP_ADD;
        c.m[M_MEMREAD]    = 1'b1;
        c.wb[WB_REGWRITE] = 1'b1;
        c.wb[WB_MEMTOREG] = 1'b1;
      end
      OP_SW: begin
        c.alusrc          = 1'b1;
        c.aluop           = ALUOP_ADD;
        c.m[M_MEMWRITE]   = 1'b1;
      end
      OP_BEQ: begin
        c.aluop           = ALUOP_SUB;
        c.m[M_BRANCH]     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/idecode_if.sv
// IF/ID and MEM/WB inputs plus the ID/EX latch outputs of the decode stage.
interface idecode_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [DATA_W-1:0] IF_ID_instr;
  logic [DATA_W-1:0] IF_ID_npc;
  logic              EX_MEM_PCSrc;
  logic              MEM_WB_RegWrite;
  logic [REG_AW-1:0] MEM_WB_rd;
  logic [DATA_W-1:0] MEM_WB_wdata;

  logic [1:0]        ID_EX_wb_ctl;
  logic [2:0]        ID_EX_m_ctl;
  logic              ID_EX_RegDst;
  logic [1:0]        ID_EX_ALUOp;
  logic              ID_EX_ALUSrc;
  logic [DATA_W-1:0] ID_EX_npc;
  logic [DATA_W-1:0] ID_EX_rdata1;
  logic [DATA_W-1:0] ID_EX_rdata2;
  logic [DATA_W-1:0] ID_EX_sext;
  logic [REG_AW-1:0] ID_EX_rt;
  logic [REG_AW-1:0] ID_EX_rd;

  modport master (
    output IF_ID_instr, IF_ID_npc, EX_MEM_PCSrc, MEM_WB_RegWrite, MEM_WB_rd, MEM_WB_wdata,
    input  ID_EX_wb_ctl, ID_EX_m_ctl, ID_EX_RegDst, ID_EX_ALUOp, ID_EX_ALUSrc,
           ID_EX_npc, ID_EX_rdata1, ID_EX_rdata2, ID_EX_sext, ID_EX_rt, ID_EX_rd
  );

  modport slave (
    input  IF_ID_instr, IF_ID_npc, EX_MEM_PCSrc, MEM_WB_RegWrite, MEM_WB_rd, MEM_WB_wdata,
    output ID_EX_wb_ctl, ID_EX_m_ctl, ID_EX_RegDst, ID_EX_ALUOp, ID_EX_ALUSrc,
           ID_EX_npc, ID_EX_rdata1, ID_EX_rdata2, ID_EX_sext, ID_EX_rt, ID_EX_rd
  );
endinterface

// File: rtl/regfile.sv
// 2-read / 1-write register file with $0 hardwired to zero and write-through
// bypass so a same-cycle writeback is visible on the read ports.
module regfile #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);
  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] regs_q [NREG];
  logic              wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    if (raddr1_i != '0) rdata1_o = (wr_en && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
    if (raddr2_i != '0) rdata2_o = (wr_en && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
  end

endmodule

// File: rtl/idecode.sv
// MIPS instruction-decode stage: control decode, sign extend, register file
// and the ID/EX latch, with control squashed to a bubble on a taken branch.
module idecode
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic       clk,
  input logic       rst,
  idecode_if.slave  bus
);
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] rd1, rd2;

  ctl_t              ctl_d,  ctl_q;
  logic [DATA_W-1:0] npc_d,  npc_q;
  logic [DATA_W-1:0] rd1_d,  rd1_q;
  logic [DATA_W-1:0] rd2_d,  rd2_q;
  logic [DATA_W-1:0] sext_d, sext_q;
  logic [REG_AW-1:0] rt_d,   rt_q;
  logic [REG_AW-1:0] rd_d,   rd_q;

  assign instr = bus.IF_ID_instr;

  regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (instr[25:21]),
    .raddr2_i (instr[20:16]),
    .rdata1_o (rd1),
    .rdata2_o (rd2),
    .we_i     (bus.MEM_WB_RegWrite),
    .waddr_i  (bus.MEM_WB_rd),
    .wdata_i  (bus.MEM_WB_wdata)
  );

  always_comb begin
    ctl_d  = decode_ctl(instr[31:26]);
    // Taken branch: only control is squashed, data still latches.
    if (bus.EX_MEM_PCSrc) ctl_d = '0;
    npc_d  = bus.IF_ID_npc;
    rd1_d  = rd1;
    rd2_d  = rd2;
    sext_d = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    rt_d   = instr[20:16];
    rd_d   = instr[15:11];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q  <= '0;
      npc_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      sext_q <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctl_q  <= ctl_d;
      npc_q  <= npc_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      sext_q <= sext_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
    end
  end

  assign bus.ID_EX_wb_ctl = ctl_q.wb;
  assign bus.ID_EX_m_ctl  = ctl_q.m;
  assign bus.ID_EX_RegDst = ctl_q.regdst;
  assign bus.ID_EX_ALUOp  = ctl_q.aluop;
  assign bus.ID_EX_ALUSrc = ctl_q.alusrc;
  assign bus.ID_EX_npc    = npc_q;
  assign bus.ID_EX_rdata1 = rd1_q;
  assign bus.ID_EX_rdata2 = rd2_q;
  assign bus.ID_EX_sext   = sext_q;
  assign bus.ID_EX_rt     = rt_q;
  assign bus.ID_EX_rd     = rd_q;

endmodule

// File: tb/tb_idecode.sv
// Directed + random bench for idecode against an opcode-table / register-array model.
module tb_idecode;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  idecode_if #(.DATA_W(32), .REG_AW(5)) bus ();
  idecode #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rf [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {RegDst, ALUOp, ALUSrc, m, wb} straight from the opcode table
  function automatic logic [8:0] ctl_model(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b1_10_0_000_10;
      6'h23:   return 9'b0_00_1_010_11;
      6'h2B:   return 9'b0_00_1_001_00;
      6'h04:   return 9'b0_01_0_100_00;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return rf[a];
  endfunction

  // Drive one instruction for one cycle and check the ID/EX latch after the edge.
  task automatic step(input logic [31:0] instr, input logic [31:0] npc, input logic pcsrc,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                      input logic r);
    logic [8:0]  e_ctl;
    logic [31:0] e_npc, e_r1, e_r2, e_sx;
    logic [4:0]  e_rt, e_rd;
    rst = r;
    bus.IF_ID_instr = instr;
    bus.IF_ID_npc = npc;
    bus.EX_MEM_PCSrc = pcsrc;
    bus.MEM_WB_RegWrite = we;
    bus.MEM_WB_rd = wrd;
    bus.MEM_WB_wdata = wd;
    if (r) begin
      e_ctl = 0; e_npc = 0; e_r1 = 0; e_r2 = 0; e_sx = 0; e_rt = 0; e_rd = 0;
    end else begin
      e_ctl = pcsrc ? 9'b0 : ctl_model(instr[31:26]);
      e_npc = npc;
      e_r1  = rd_model(instr[25:21], we, wrd, wd);
      e_r2  = rd_model(instr[20:16], we, wrd, wd);
      e_sx  = instr[15] ? (32'hFFFF0000 | {16'h0, instr[15:0]}) : {16'h0, instr[15:0]};
      e_rt  = instr[20:16];
      e_rd  = instr[15:11];
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    end else if (we && wrd != 0) begin
      rf[wrd] = wd;
    end
    @(negedge clk);
    chk("ctl", {bus.ID_EX_RegDst, bus.ID_EX_ALUOp, bus.ID_EX_ALUSrc, bus.ID_EX_m_ctl, bus.ID_EX_wb_ctl}, e_ctl);
    chk("npc", bus.ID_EX_npc, e_npc);
    chk("rdata1", bus.ID_EX_rdata1, e_r1);
    chk("rdata2", bus.ID_EX_rdata2, e_r2);
    chk("sext", bus.ID_EX_sext, e_sx);
    chk("rt", bus.ID_EX_rt, e_rt);
    chk("rd", bus.ID_EX_rd, e_rd);
  endtask

  initial begin
    logic [31:0] rnd, ins;
    logic [5:0]  op;
    logic [4:0]  idx;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    bus.IF_ID_instr = 0; bus.IF_ID_npc = 0; bus.EX_MEM_PCSrc = 0;
    bus.MEM_WB_RegWrite = 0; bus.MEM_WB_rd = 0; bus.MEM_WB_wdata = 0;
    @(negedge clk);

    // reset with random instruction and writeback
    step($urandom(), $urandom(), 1'b0, 1'b1, 5'd9, $urandom(), 1'b1);
    step($urandom(), $urandom(), 1'b0, 1'b1, 5'd9, $urandom(), 1'b1);
    chk("rst_wb", bus.ID_EX_wb_ctl, 2'b00);
    chk("rst_sext", bus.ID_EX_sext, 32'h0);
    for (int i = 1; i < 32; i++) begin
      idx = 5'(i);
      ins = {6'h00, idx, idx, 16'h0};
      step(ins, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      chk("rst_reg_zero", bus.ID_EX_rdata1, 32'h0);
    end

    // R-type add $3,$1,$2
    step(32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 32'd5, 1'b0);
    step(32'h0, 32'h0, 1'b0, 1'b1, 5'd2, 32'd7, 1'b0);
    step(32'h00221820, 32'h4, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("add_rdata1", bus.ID_EX_rdata1, 32'd5);
    chk("add_rdata2", bus.ID_EX_rdata2, 32'd7);
    chk("add_rt", bus.ID_EX_rt, 5'd2);
    chk("add_rd", bus.ID_EX_rd, 5'd3);
    chk("add_ctl", {bus.ID_EX_RegDst, bus.ID_EX_ALUOp, bus.ID_EX_ALUSrc, bus.ID_EX_m_ctl, bus.ID_EX_wb_ctl}, 9'b1_10_0_000_10);
    chk("add_npc", bus.ID_EX_npc, 32'h4);

    // lw negative offset
    step(32'h8C24FFFC, 32'h8, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("lw_sext", bus.ID_EX_sext, 32'hFFFFFFFC);
    chk("lw_alusrc", bus.ID_EX_ALUSrc, 1'b1);
    chk("lw_m", bus.ID_EX_m_ctl, 3'b010);
    chk("lw_wb", bus.ID_EX_wb_ctl, 2'b11);
    chk("lw_rt", bus.ID_EX_rt, 5'd4);

    // write-through bypass, then $0 stays zero
    step(32'h00A00020, 32'hC, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    chk("bypass", bus.ID_EX_rdata1, 32'hDEADBEEF);
    step(32'h0, 32'h10, 1'b0, 1'b1, 5'd0, 32'h1234, 1'b0);
    step(32'h00000020, 32'h14, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("reg0", bus.ID_EX_rdata1, 32'h0);

    // flush on beq, then normal decode; writeback during flush still commits
    step(32'h10220003, 32'h18, 1'b1, 1'b1, 5'd6, 32'h66, 1'b0);
    chk("flush_m", bus.ID_EX_m_ctl, 3'b000);
    chk("flush_aluop", bus.ID_EX_ALUOp, 2'b00);
    step(32'h10C20003, 32'h1C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("beq_m", bus.ID_EX_m_ctl, 3'b100);
    chk("beq_aluop", bus.ID_EX_ALUOp, 2'b01);
    chk("flush_wb_commit", bus.ID_EX_rdata1, 32'h66);

    // unknown opcode, then reset racing a writeback to $7
    step(32'hFC221820, 32'h20, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("op3f_ctl", {bus.ID_EX_RegDst, bus.ID_EX_ALUOp, bus.ID_EX_ALUSrc, bus.ID_EX_m_ctl, bus.ID_EX_wb_ctl}, 9'b0);
    step(32'h0, 32'h0, 1'b0, 1'b1, 5'd7, 32'h77, 1'b0);
    step(32'h00E00020, 32'h24, 1'b0, 1'b1, 5'd7, 32'h99, 1'b1);
    step(32'h00E00020, 32'h28, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("rst_drops_wb", bus.ID_EX_rdata1, 32'h0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h3F;
        default: op = 6'($urandom());
      endcase
      rnd = $urandom();
      ins = {op, rnd[25:0]};
      step(ins, $urandom(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
           5'($urandom()), $urandom(), ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/idecode.md
Name: idecode

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline; consumes the IF/ID latch that ifetch drives (IF_ID_instr, IF_ID_npc).
- Owns the 32x32 register file, including writeback from MEM/WB, the main control decoder, the sign extender and the ID/EX pipeline latch.
- Squashes the decoded instruction into a bubble when EX_MEM_PCSrc redirects fetch.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_AW, 5, register-address width (2^REG_AW registers).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- IF_ID_instr  in  32  instruction from IF/ID latch
- IF_ID_npc  in  32  PC+4 from IF/ID latch
- EX_MEM_PCSrc  in  1  taken branch in MEM; flush ID/EX control this cycle
- MEM_WB_RegWrite  in  1  writeback enable
- MEM_WB_rd  in  5  writeback register
- MEM_WB_wdata  in  32  writeback data
- ID_EX_wb_ctl  out  2  {RegWrite, MemtoReg}
- ID_EX_m_ctl  out  3  {Branch, MemRead, MemWrite}
- ID_EX_RegDst  out  1  EX destination-register select
- ID_EX_ALUOp  out  2  ALU control class
- ID_EX_ALUSrc  out  1  EX ALU B-operand select
- ID_EX_npc  out  32  latched PC+4
- ID_EX_rdata1  out  32  rs read data
- ID_EX_rdata2  out  32  rt read data
- ID_EX_sext  out  32  sign-extended instr[15:0]
- ID_EX_rt  out  5  instr[20:16]
- ID_EX_rd  out  5  instr[15:11]

Behaviour:
- Reset:
  - On a clk edge with rst=1, every ID_EX_* output becomes 0 and all 32 registers clear to 0.
  - Reset mid-stream discards the in-flight instruction and any concurrent writeback.
- Latency: one cycle. Decode is combinational from IF_ID_*; the result appears on ID_EX_* after the next rising edge.
- Control decode by opcode, instr[31:26]. Values below are listed as RegDst, ALUOp, ALUSrc, m_ctl, wb_ctl:
  - R-type (0x00): 1, 10, 0, 000, 10
  - lw (0x23): 0, 00, 1, 010, 11
  - sw (0x2B): 0, 00, 1, 001, 00
  - beq (0x04): 0, 01, 0, 100, 00
  - Any other opcode: all control fields 0, i.e. treated as a bubble. Data fields still latch.
  - All-zero instruction decodes as R-type writing $0, which is a harmless nop.
- Sign extend: ID_EX_sext = {{16{instr[15]}}, instr[15:0]}.
- Register file:
  - Two combinational read ports (rs = instr[25:21], rt = instr[20:16]) and one synchronous write port.
  - A write occurs on the edge when MEM_WB_RegWrite=1 and MEM_WB_rd!=0.
  - Register 0 always reads 0; writes to it are ignored.
- Write-through bypass: if a read address equals MEM_WB_rd in the same cycle, with MEM_WB_RegWrite=1 and address !=0, the read returns MEM_WB_wdata. ID/EX therefore captures the new value in the same edge as the write.
- Flush:
  - When EX_MEM_PCSrc=1, the control fields ID_EX_wb_ctl, ID_EX_m_ctl, RegDst, ALUOp and ALUSrc load 0.
  - Data fields load normally and are don't-care.
  - A writeback in the same cycle still commits.
- No stall input: the ID/EX latch updates every non-reset cycle. Hazard detection and forwarding live in later blocks.
- Simultaneous rst and flush: rst wins.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ.
  - ALUOp encodings ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - Bit-position constants for the wb_ctl and m_ctl fields.
- One sub-module, regfile: 2R1W, reset clear, $0 hardwired, write-through bypass. Control decode and the latch stay in idecode.

Test Plan:
- Reset: rst=1 for 2 cycles with random instr -> all ID_EX_* = 0. Afterwards, reading $1..$31 returns 0.
- R-type: write $1=5 and $2=7 via MEM_WB, then instr 0x00221820 (add $3,$1,$2), npc=0x4 -> next edge rdata1=5, rdata2=7, rt=2, rd=3, RegDst=1, ALUOp=10, ALUSrc=0, m=000, wb=10, npc=0x4.
- lw with negative offset: instr 0x8C24FFFC -> sext=0xFFFFFFFC, ALUSrc=1, m=010, wb=11, rt=4.
- Bypass and $0:
  - MEM_WB writes $5=0xDEADBEEF in the same cycle as instr 0x00A00020 reading rs=$5 -> rdata1=0xDEADBEEF.
  - MEM_WB write to $0 with 0x1234 -> later read of $0 = 0.
- Flush: beq 0x10220003 with EX_MEM_PCSrc=1 -> all ID_EX control fields 0. The next instruction with PCSrc=0 decodes normally.
- Unknown opcode 0x3F and mid-stream reset: opcode 0x3F gives all control fields 0. rst asserted together with a writeback to $7 -> $7 reads 0 after reset.
